alu_cmd_ctrl: RTL

Command front-end that drives the register-output ALU (Enable/A/B/ALU_FUN in, ALU_OUT/OUT_VALID out). It parses an incoming byte stream into ALU operation frames and issues a one-cycle enable to the ALU. It then waits for the registered result and streams it out as bytes, LSB first, over a ready/valid interface toward the TX path.

---
 rtl/alu_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : alu_cmd_ctrl
// Purpose  : Command front-end for a register-output ALU. Parses a byte stream
//            into operation frames, issues a one-cycle ALU enable, waits for
//            the registered result and streams it back LSB first over a
//            ready/valid byte interface.
//
// Frames   : header {marker, fun}; marker 'hC = header, A, B (full frame);
//            marker 'hD = header only, reuses stored A/B (short frame).
//
// Ports    : CLK, RST        - clock, asynchronous active-high reset
//            RX_DATA/VALID   - incoming command/operand bytes (no backpressure)
//            ALU_EN/A/B/FUN  - registered ALU request
//            ALU_OUT/VALID   - ALU result and its valid strobe
//            TX_DATA/VALID/READY - response byte stream
//            BUSY            - high whenever the FSM is not idle
//            FRAME_ERR       - one-cycle error pulse
//
// Option   : define ALU_CMD_ECHO_EN to prefix the response with the latched
//            header byte (three-byte response).
//
// Revision : 1.0 - initial release
//==============================================================================
module alu_cmd_ctrl #(
   parameter int OP_WIDTH       = 8,
   parameter int FUNC_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [OP_WIDTH-1:0]   RX_DATA,
   input  logic                  RX_VALID,
   output logic                  ALU_EN,
   output logic [OP_WIDTH-1:0]   ALU_A,
   output logic [OP_WIDTH-1:0]   ALU_B,
   output logic [FUNC_WIDTH-1:0] ALU_FUN,
   input  logic [2*OP_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_VALID,
   output logic [OP_WIDTH-1:0]   TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic                  BUSY,
   output logic                  FRAME_ERR
);

   localparam int c_MARK_W = OP_WIDTH - FUNC_WIDTH;
   localparam logic [c_MARK_W-1:0] c_MARK_FULL  = c_MARK_W'(4'hC);
   localparam logic [c_MARK_W-1:0] c_MARK_SHORT = c_MARK_W'(4'hD);
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef ALU_CMD_ECHO_EN
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_A    = 3'd1,
      S_GET_B    = 3'd2,
      S_EXEC     = 3'd3,
      S_WAIT     = 3'd4,
      S_SEND_LO  = 3'd5,
      S_SEND_HI  = 3'd6,
      S_SEND_HDR = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GET_A   = 3'd1,
      S_GET_B   = 3'd2,
      S_EXEC    = 3'd3,
      S_WAIT    = 3'd4,
      S_SEND_LO = 3'd5,
      S_SEND_HI = 3'd6
   } state_t;
`endif

   state_t                  state_q, state_d;
   logic [OP_WIDTH-1:0]     a_q, a_d;          // stored operands, survive short frames
   logic [OP_WIDTH-1:0]     b_q, b_d;
   logic [FUNC_WIDTH-1:0]   fun_q, fun_d;
   logic                    alu_en_q, alu_en_d;
   logic [OP_WIDTH-1:0]     alu_a_q, alu_a_d;
   logic [OP_WIDTH-1:0]     alu_b_q, alu_b_d;
   logic [FUNC_WIDTH-1:0]   alu_fun_q, alu_fun_d;
   logic [2*OP_WIDTH-1:0]   res_q, res_d;
   logic [c_CNT_W-1:0]      cnt_q, cnt_d;
   logic [OP_WIDTH-1:0]     tx_data_q, tx_data_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    frame_err_q, frame_err_d;
`ifdef ALU_CMD_ECHO_EN
   logic [OP_WIDTH-1:0]     hdr_q, hdr_d;
`endif

   logic [c_MARK_W-1:0]     w_marker;
   logic                    w_tx_fire;
   logic                    w_overrun;

   assign w_marker  = RX_DATA[OP_WIDTH-1:FUNC_WIDTH];
   assign w_tx_fire = tx_valid_q && TX_READY;
   // Any byte arriving once the frame is complete is dropped as an overrun.
   assign w_overrun = RX_VALID && (state_q != S_IDLE) &&
                      (state_q != S_GET_A) && (state_q != S_GET_B);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      fun_d       = fun_q;
      alu_en_d    = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_fun_d   = alu_fun_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      frame_err_d = 1'b0;
`ifdef ALU_CMD_ECHO_EN
      hdr_d       = hdr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (RX_VALID) begin
               if (w_marker == c_MARK_FULL) begin
                  fun_d   = RX_DATA[FUNC_WIDTH-1:0];
                  state_d = S_GET_A;
`ifdef ALU_CMD_ECHO_EN
                  hdr_d   = RX_DATA;
`endif
               end else if (w_marker == c_MARK_SHORT) begin
                  // Short frame: issue straight away with the stored operands.
                  fun_d     = RX_DATA[FUNC_WIDTH-1:0];
                  alu_a_d   = a_q;
                  alu_b_d   = b_q;
                  alu_fun_d = RX_DATA[FUNC_WIDTH-1:0];
                  alu_en_d  = 1'b1;
                  state_d   = S_EXEC;
`ifdef ALU_CMD_ECHO_EN
                  hdr_d     = RX_DATA;
`endif
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         S_GET_A: begin
            if (RX_VALID) begin
               a_d     = RX_DATA;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (RX_VALID) begin
               b_d       = RX_DATA;
               alu_a_d   = a_q;
               alu_b_d   = RX_DATA;
               alu_fun_d = fun_q;
               alu_en_d  = 1'b1;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ALU_VALID) begin
               res_d      = ALU_OUT;
               tx_valid_d = 1'b1;
`ifdef ALU_CMD_ECHO_EN
               tx_data_d  = hdr_q;
               state_d    = S_SEND_HDR;
`else
               tx_data_d  = ALU_OUT[OP_WIDTH-1:0];
               state_d    = S_SEND_LO;
`endif
            end else if (cnt_q == c_CNT_LAST) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end
`ifdef ALU_CMD_ECHO_EN
         S_SEND_HDR: begin
            if (w_tx_fire) begin
               tx_data_d = res_q[OP_WIDTH-1:0];
               state_d   = S_SEND_LO;
            end
         end
`endif
         S_SEND_LO: begin
            if (w_tx_fire) begin
               tx_data_d = res_q[2*OP_WIDTH-1:OP_WIDTH];
               state_d   = S_SEND_HI;
            end
         end
         S_SEND_HI: begin
            if (w_tx_fire) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Merged with any FSM error so coincident sources give one pulse.
      if (w_overrun) begin
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         fun_q       <= '0;
         alu_en_q    <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef ALU_CMD_ECHO_EN
         hdr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         fun_q       <= fun_d;
         alu_en_q    <= alu_en_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_fun_q   <= alu_fun_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         frame_err_q <= frame_err_d;
`ifdef ALU_CMD_ECHO_EN
         hdr_q       <= hdr_d;
`endif
      end
   end

   assign ALU_EN    = alu_en_q;
   assign ALU_A     = alu_a_q;
   assign ALU_B     = alu_b_q;
   assign ALU_FUN   = alu_fun_q;
   assign TX_DATA   = tx_data_q;
   assign TX_VALID  = tx_valid_q;
   assign BUSY      = (state_q != S_IDLE);
   assign FRAME_ERR = frame_err_q;

endmodule
`default_nettype wire
